// File: rtl/terminal_input_fifo.sv
// Byte FIFO feeding the terminal stream decoder: buffers receiver bytes, drives RTS
// from fill level, and paces bytes out as 1-cycle strobes gated by the decoder's ready_n.
module terminal_input_fifo #(
  parameter int ADDR_BITS = 9,
  parameter int AF_MARGIN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           unicode,
  output logic                 unicode_available,
  input  logic                 ready_n,
  output logic                 rts_n,
  output logic                 overflow,
  output logic [ADDR_BITS:0]   fill_level
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL    = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] HALF    = {2'b01, {(ADDR_BITS-1){1'b0}}};
  localparam logic [ADDR_BITS:0] HI_MARK = FULL - (ADDR_BITS+1)'(AF_MARGIN);

  typedef enum logic {S_WAIT, S_GAP} state_t;

  state_t               state;
  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic                 pop;
  logic                 push;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  always_comb begin
    pop  = (state == S_WAIT) && (count != '0) && !ready_n;
    push = rx_valid && ((count != FULL) || pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      unicode           <= '0;
      unicode_available <= 1'b0;
      rts_n             <= 1'b0;
      overflow          <= 1'b0;
      state             <= S_WAIT;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rx_valid && !push) overflow <= 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Hysteresis band between HALF and HI_MARK keeps rts_n from chattering.
      if (count >= HI_MARK)   rts_n <= 1'b1;
      else if (count <= HALF) rts_n <= 1'b0;

      case (state)
        S_WAIT: begin
          if (pop) begin
            unicode           <= mem[rd_ptr];
            unicode_available <= 1'b1;
            rd_ptr            <= rd_ptr + 1'b1;
            state             <= S_GAP;
          end else begin
            unicode_available <= 1'b0;
          end
        end
        S_GAP: begin
          unicode_available <= 1'b0;
          state             <= S_WAIT;
        end
        default: begin
          unicode_available <= 1'b0;
          state             <= S_WAIT;
        end
      endcase
    end
  end

  assign fill_level = count;

endmodule
